pipe_result_collector: RTL and testbench

//  Sink at the output end of the bit-level pipeline (modul_top). Tags every accepted

---
 rtl/pipe_result_collector.sv | 107 ++++++++++
 tb/tb_pipe_result_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_collector.sv
// Result sink for the bit-level pipeline: aligns each load with its result bit f,
// packs results LSB-first into words and queues them in a small FIFO for a consumer.
module pipe_result_collector #(
    parameter int LATENCY = 3,
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       f,
    output logic [WORD_W-1:0]          word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WORD_W)-1:0]  bit_cnt,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int CW = $clog2(WORD_W);
    localparam int AW = $clog2(DEPTH);

    logic [LATENCY-1:0] r_tag;
    logic [WORD_W-2:0]  r_pack;
    logic [CW-1:0]      r_bit_cnt;
    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_ovf;

    logic               w_cap;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic [WORD_W-1:0]  w_word;

    // A set bit leaving the tag line marks the edge where the matching f is valid.
    generate
        if (LATENCY == 1) begin : g_tag1
            always_ff @(posedge clk) begin
                if (clr) r_tag <= '0;
                else     r_tag <= load;
            end
        end else begin : g_tagn
            always_ff @(posedge clk) begin
                if (clr) r_tag <= '0;
                else     r_tag <= {r_tag[LATENCY-2:0], load};
            end
        end
    endgenerate

    assign w_cap  = r_tag[LATENCY-1];
    assign w_last = (r_bit_cnt == CW'(WORD_W - 1));
    assign w_push = w_cap && w_last;
    assign w_word = {f, r_pack};
    assign w_pop  = (r_count != '0) && word_ready;
    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_wr   = w_push && (!w_full || w_pop);

    // The final bit of a word bypasses the pack register straight into the FIFO.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pack    <= '0;
            r_bit_cnt <= '0;
        end else if (w_cap) begin
            if (w_last) begin
                r_bit_cnt <= '0;
            end else begin
                r_pack[r_bit_cnt] <= f;
                r_bit_cnt         <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            // When full, a simultaneous pop frees the slot the new word lands in.
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign word_data  = r_mem[r_rd_ptr];
    assign word_valid = (r_count != '0);
    assign bit_cnt    = r_bit_cnt;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Self-checking bench for pipe_result_collector: directed scenarios plus a random run
// checked against a queue-based model of load history, packed bits and stored words.
module tb_pipe_result_collector;

    localparam int LAT = 3;
    localparam int WW  = 8;
    localparam int DEP = 4;

    logic          clk;
    logic          clr;
    logic          load;
    logic          f;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic [2:0]    bit_cnt;
    logic [2:0]    fifo_count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit            lh[$];
    logic [WW-1:0] mw;
    int            mcnt;
    logic [WW-1:0] mq[$];
    bit            movf;

    pipe_result_collector #(.LATENCY(LAT), .WORD_W(WW), .DEPTH(DEP)) dut (
        .clk(clk), .clr(clr), .load(load), .f(f),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .bit_cnt(bit_cnt), .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        lh = {};
        repeat (LAT) lh.push_back(1'b0);
        mw   = '0;
        mcnt = 0;
        mq   = {};
        movf = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, settle 1 time unit past the edge.
    task automatic drive(input bit c, input bit l, input bit fv, input bit r);
        bit cap;
        clr = c; load = l; f = fv; word_ready = r;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            cap = lh.pop_front();
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (cap) begin
                mw[mcnt] = fv;
                mcnt++;
                if (mcnt == WW) begin
                    if (mq.size() < DEP) mq.push_back(mw);
                    else movf = 1'b1;
                    mcnt = 0;
                end
            end
            lh.push_back(l);
        end
        #1;
    endtask

    // Loads WW consecutive samples whose results spell w LSB-first; ready only at ready_step.
    task automatic send_word(input logic [WW-1:0] w, input int ready_step);
        for (int t = 0; t < WW + LAT; t++)
            drive(1'b0, t < WW, (t >= LAT) ? w[t-LAT] : 1'($urandom), t == ready_step);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", word_valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (bit_cnt !== 3'd0) begin bad++; $display("FAIL rst_bitcnt: got %0d want 0", bit_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_single_word();
        logic [WW-1:0] pat;
        pat = 8'h4D;
        for (int t = 0; t <= 10; t++) begin
            drive(1'b0, t < 8, (t >= LAT) ? pat[t-LAT] : 1'b0, 1'b1);
            if (t == 9) begin
                total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL sw_early: got valid=%b want 0", word_valid); end
            end
        end
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL sw_valid: got %b want 1", word_valid); end
        total++; if (word_data !== 8'h4D) begin bad++; $display("FAIL sw_data: got %h want 4d", word_data); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (word_valid !== 1'b0 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL sw_oneshot: got valid=%b count=%0d want 0/0", word_valid, fifo_count);
        end
    endtask

    task automatic test_gap();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 6; t++) drive(1'b0, t == 0, 1'(t), 1'b0);
        total++; if (bit_cnt !== 3'd1) begin bad++; $display("FAIL gap_bitcnt: got %0d want 1", bit_cnt); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL gap_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_overflow();
        logic [WW-1:0] words [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_word(words[i], -1);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (word_valid !== 1'b1 || word_data !== words[i]) begin
                bad++; $display("FAIL ovf_drain%0d: got valid=%b data=%h want 1/%h", i, word_valid, word_data, words[i]);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        total++; if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_empty: got valid=%b ovf=%b want 0/1", word_valid, overflow);
        end
    endtask

    task automatic test_full_pushpop();
        logic [WW-1:0] words [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_word(words[i], -1);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL pp_fill: got %0d want 4", fifo_count); end
        send_word(words[4], WW - 1 + LAT);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf: got %b want 0", overflow); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL pp_count: got %0d want 4", fifo_count); end
        for (int i = 1; i < 5; i++) begin
            total++; if (word_valid !== 1'b1 || word_data !== words[i]) begin
                bad++; $display("FAIL pp_drain%0d: got valid=%b data=%h want 1/%h", i, word_valid, word_data, words[i]);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_clr_midword();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, -1);
        send_word(8'hC3, -1);
        for (int t = 0; t < 8; t++) drive(1'b0, 1'b1, 1'($urandom), 1'b0);
        total++; if (bit_cnt !== 3'd5 || fifo_count !== 3'd2) begin
            bad++; $display("FAIL clr_pre: got bitcnt=%0d count=%0d want 5/2", bit_cnt, fifo_count);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (bit_cnt !== 3'd0 || fifo_count !== 3'd0 || word_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL clr_mid: got bitcnt=%0d count=%0d valid=%b ovf=%b want 0/0/0/0",
                            bit_cnt, fifo_count, word_valid, overflow);
        end
        send_word(8'hA5, -1);
        total++; if (fifo_count !== 3'd1 || bit_cnt !== 3'd0) begin
            bad++; $display("FAIL clr_post_count: got count=%0d bitcnt=%0d want 1/0", fifo_count, bit_cnt);
        end
        total++; if (word_data !== 8'hA5) begin bad++; $display("FAIL clr_post_data: got %h want a5", word_data); end
    endtask

    task automatic test_random();
        bit c, l, fv, r;
        for (int n = 0; n < 600; n++) begin
            c  = ($urandom_range(0, 149) == 0);
            l  = ($urandom_range(0, 3) != 0);
            fv = 1'($urandom);
            r  = ($urandom_range(0, 2) == 0);
            drive(c, l, fv, r);
            total++; if (word_valid !== (mq.size() > 0)) begin
                bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, word_valid, mq.size() > 0);
            end
            total++; if (fifo_count !== 3'(mq.size())) begin
                bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, fifo_count, mq.size());
            end
            total++; if (bit_cnt !== 3'(mcnt)) begin
                bad++; $display("FAIL rnd_bitcnt@%0d: got %0d want %0d", n, bit_cnt, mcnt);
            end
            total++; if (overflow !== movf) begin
                bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, overflow, movf);
            end
            if (mq.size() > 0) begin
                total++; if (word_data !== mq[0]) begin
                    bad++; $display("FAIL rnd_data@%0d: got %h want %h", n, word_data, mq[0]);
                end
            end
        end
    endtask

    initial begin
        clr = 1'b1; load = 1'b0; f = 1'b0; word_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_word();
        test_gap();
        test_overflow();
        test_full_pushpop();
        test_clr_midword();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
